// File: rtl/warp_pkg.sv
// Shared types and constants for the warp fetch stage: FSM encoding,
// reset PC, instruction width and the layout of one buffered instruction.
package warp_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC  = 64'h0000_0000_8000_0000;
  localparam int          INST_W            = 32;
  localparam int          FETCH_BLOCK_BYTES = 8;

  typedef enum logic [1:0] {
    FETCH_STATE_REQ     = 2'd0,
    FETCH_STATE_WAIT    = 2'd1,
    FETCH_STATE_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [63:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/warp_fetch_buffer.sv
// Instruction FIFO between fetch and decode: up to two pushes and one pop
// per cycle, with a synchronous flush that wins over everything else.
module warp_fetch_buffer
  import warp_pkg::*;
#(
  parameter int BUF_DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       flush,
  input  logic                       push0,
  input  logic                       push1,
  input  fetch_entry_t               entry0,
  input  fetch_entry_t               entry1,
  input  logic                       pop,
  output logic                       head_valid,
  output fetch_entry_t               head,
  output logic [$clog2(BUF_DEPTH):0] count
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       push_n;

  assign push_n     = {1'b0, push0} + {1'b0, push1};
  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];

  // Storage needs no reset; entry1 always lands right behind entry0.
  always_ff @(posedge i_clk) begin
    if (!flush) begin
      if (push0) mem[wr_ptr] <= entry0;
      if (push1) mem[wr_ptr + PTR_W'(1)] <= entry1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push_n) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/warp_fetch.sv
// Fetch stage: owns the PC, issues one aligned 8-byte icache read at a time,
// splits responses into instructions and handles branch/trap redirects.
module warp_fetch
  import warp_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect_valid,
  input  logic [63:0] i_redirect_pc,
  input  logic        i_req_ready,
  output logic        o_req_valid,
  output logic [33:0] o_req_raddr,
  input  logic        i_res_valid,
  output logic        o_res_ready,
  input  logic [63:0] i_res_rdata,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [63:0] o_inst_pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [63:0]      pc;
  logic [63:0]      req_pc;
  logic [63:0]      pending_pc;
  logic             redirect_pending;
  logic [63:0]      redirect_target;
  logic [1:0]       unused_redirect_bits;
  logic [CNT_W-1:0] buf_count;
  logic             req_fire;
  logic             push0;
  logic             push1;
  logic             pop;
  fetch_entry_t     entry0;
  fetch_entry_t     entry1;
  fetch_entry_t     head;

  assign redirect_target      = {i_redirect_pc[63:2], 2'b00};
  assign unused_redirect_bits = i_redirect_pc[1:0];
  assign req_fire             = o_req_valid & i_req_ready;
  assign o_req_raddr          = {pc[33:3], 3'b000};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= FETCH_STATE_REQ;
    else          state <= state_next;
  end

  // A request accepted under a redirect (or with one parked) returns stale data.
  always_comb begin
    state_next = state;
    case (state)
      FETCH_STATE_REQ:
        if (req_fire)
          state_next = (i_redirect_valid || redirect_pending) ? FETCH_STATE_DISCARD
                                                              : FETCH_STATE_WAIT;
      FETCH_STATE_WAIT:
        if (i_redirect_valid)
          state_next = i_res_valid ? FETCH_STATE_REQ : FETCH_STATE_DISCARD;
        else if (i_res_valid)
          state_next = FETCH_STATE_REQ;
      FETCH_STATE_DISCARD:
        if (i_res_valid) state_next = FETCH_STATE_REQ;
      default: state_next = FETCH_STATE_REQ;
    endcase
  end

  always_comb begin
    o_req_valid = 1'b0;
    o_res_ready = 1'b0;
    case (state)
      FETCH_STATE_REQ:     o_req_valid = i_rst_n && (buf_count <= CNT_W'(BUF_DEPTH - 2));
      FETCH_STATE_WAIT:    o_res_ready = 1'b1;
      FETCH_STATE_DISCARD: o_res_ready = 1'b1;
      default: ;
    endcase
  end

  // A redirect hitting a request still waiting on ready is parked so the
  // driven address stays stable until the handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc               <= RESET_PC;
      req_pc           <= RESET_PC;
      pending_pc       <= RESET_PC;
      redirect_pending <= 1'b0;
    end else if (i_redirect_valid) begin
      if (state == FETCH_STATE_REQ && o_req_valid && !i_req_ready) begin
        redirect_pending <= 1'b1;
        pending_pc       <= redirect_target;
      end else begin
        redirect_pending <= 1'b0;
        pc               <= redirect_target;
      end
    end else if (req_fire) begin
      if (redirect_pending) begin
        redirect_pending <= 1'b0;
        pc               <= pending_pc;
      end else begin
        req_pc <= pc;
        pc     <= {pc[63:3], 3'b000} + 64'(FETCH_BLOCK_BYTES);
      end
    end
  end

  always_comb begin
    push0       = (state == FETCH_STATE_WAIT) && i_res_valid && !i_redirect_valid;
    push1       = push0 && !req_pc[2];
    pop         = o_inst_valid && i_inst_ready && !i_redirect_valid;
    entry0.pc   = req_pc;
    entry0.inst = req_pc[2] ? i_res_rdata[63:32] : i_res_rdata[31:0];
    entry1.pc   = req_pc + 64'd4;
    entry1.inst = i_res_rdata[63:32];
  end

  warp_fetch_buffer #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buffer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .flush     (i_redirect_valid),
    .push0     (push0),
    .push1     (push1),
    .entry0    (entry0),
    .entry1    (entry1),
    .pop       (pop),
    .head_valid(o_inst_valid),
    .head      (head),
    .count     (buf_count)
  );

  assign o_inst    = head.inst;
  assign o_inst_pc = head.pc;

endmodule

// File: tb/tb_warp_fetch.sv
// Directed bench for warp_fetch: a cycle table for the basic fetch/redirect
// flow plus hand-written sequences around backpressure, redirects and reset.
module tb_warp_fetch;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_redirect_valid = 1'b0;
  logic [63:0] i_redirect_pc = '0;
  logic        i_req_ready = 1'b0;
  logic        o_req_valid;
  logic [33:0] o_req_raddr;
  logic        i_res_valid = 1'b0;
  logic        o_res_ready;
  logic [63:0] i_res_rdata = '0;
  logic        o_inst_valid;
  logic        i_inst_ready = 1'b0;
  logic [31:0] o_inst;
  logic [63:0] o_inst_pc;

  int checks = 0;
  int failures = 0;

  logic        mem_busy = 1'b0;
  int          mem_lat = 0;
  logic [33:0] mem_addr = '0;
  logic [63:0] exp_next_pc = '0;
  int          popped = 0;

  typedef struct {
    logic        req_ready;
    logic        res_valid;
    logic [63:0] rdata;
    logic        inst_ready;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        exp_req_valid;
    logic [33:0] exp_raddr;
    logic        exp_res_ready;
    logic        exp_inst_valid;
    logic [31:0] exp_inst;
    logic [63:0] exp_inst_pc;
  } vec_t;

  vec_t vecs [14];

  warp_fetch dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc   (i_redirect_pc),
    .i_req_ready     (i_req_ready),
    .o_req_valid     (o_req_valid),
    .o_req_raddr     (o_req_raddr),
    .i_res_valid     (i_res_valid),
    .o_res_ready     (o_res_ready),
    .i_res_rdata     (i_res_rdata),
    .o_inst_valid    (o_inst_valid),
    .i_inst_ready    (i_inst_ready),
    .o_inst          (o_inst),
    .o_inst_pc       (o_inst_pc)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (i_rst_n && dut.buf_count > 4) begin
      $display("[TB] FAIL bufCount: got %0d limit 4", dut.buf_count);
      failures++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] memData(input logic [33:0] addr);
    logic [31:0] lo;
    logic [31:0] hi;
    lo = addr[31:0] ^ KEY;
    hi = (addr[31:0] + 32'd4) ^ KEY;
    return {hi, lo};
  endfunction

  function automatic vec_t mkVec(input logic rr, input logic rv, input logic [63:0] rd,
                                 input logic ir, input logic dv, input logic [63:0] dpc,
                                 input logic eqv, input logic [33:0] ea, input logic ers,
                                 input logic eiv, input logic [31:0] ei, input logic [63:0] ep);
    vec_t v;
    v.req_ready = rr; v.res_valid = rv; v.rdata = rd; v.inst_ready = ir;
    v.redir_valid = dv; v.redir_pc = dpc; v.exp_req_valid = eqv; v.exp_raddr = ea;
    v.exp_res_ready = ers; v.exp_inst_valid = eiv; v.exp_inst = ei; v.exp_inst_pc = ep;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rr, input logic rv, input logic [63:0] rd,
                               input logic ir, input logic dv, input logic [63:0] dpc);
    @(negedge i_clk);
    i_req_ready = rr; i_res_valid = rv; i_res_rdata = rd;
    i_inst_ready = ir; i_redirect_valid = dv; i_redirect_pc = dpc;
    #1;
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_req_ready = 1'b0; i_res_valid = 1'b0; i_res_rdata = '0;
    i_inst_ready = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = '0;
    #1;
    checkOutput("rstReqValid", 64'(o_req_valid), 64'd0);
    checkOutput("rstResReady", 64'(o_res_ready), 64'd0);
    checkOutput("rstInstValid", 64'(o_inst_valid), 64'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    mem_busy = 1'b0;
  endtask

  // Icache model answering each request 3 cycles after the handshake, plus a
  // scoreboard that expects consecutive PCs on every decode pop.
  task automatic runCycles(input int n, input logic inst_rdy);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_req_ready = 1'b1; i_redirect_valid = 1'b0; i_inst_ready = inst_rdy;
      if (mem_busy && mem_lat == 0) begin
        i_res_valid = 1'b1;
        i_res_rdata = memData(mem_addr);
      end else begin
        i_res_valid = 1'b0;
        if (mem_busy) mem_lat--;
      end
      #1;
      if (i_res_valid && o_res_ready) mem_busy = 1'b0;
      if (o_req_valid && i_req_ready) begin
        mem_busy = 1'b1; mem_lat = 2; mem_addr = o_req_raddr;
      end
      if (o_inst_valid && i_inst_ready) begin
        checkOutput("popPc", o_inst_pc, exp_next_pc);
        checkOutput("popInst", 64'(o_inst), 64'(exp_next_pc[31:0] ^ KEY));
        exp_next_pc = exp_next_pc + 64'd4;
        popped++;
      end
    end
  endtask

  initial begin
    vecs[0]  = mkVec(1, 0, 64'h0, 1, 0, 64'h0, 1, 34'h0_8000_0000, 0, 0, 32'h0, 64'h0);
    vecs[1]  = mkVec(0, 0, 64'h0, 1, 0, 64'h0, 0, 34'h0, 1, 0, 32'h0, 64'h0);
    vecs[2]  = mkVec(0, 0, 64'h0, 1, 0, 64'h0, 0, 34'h0, 1, 0, 32'h0, 64'h0);
    vecs[3]  = mkVec(0, 1, 64'hBBBB_BBBB_AAAA_AAAA, 1, 0, 64'h0, 0, 34'h0, 1, 0, 32'h0, 64'h0);
    vecs[4]  = mkVec(0, 0, 64'h0, 1, 0, 64'h0, 1, 34'h0_8000_0008, 0, 1, 32'hAAAA_AAAA, 64'h8000_0000);
    vecs[5]  = mkVec(0, 0, 64'h0, 1, 0, 64'h0, 1, 34'h0_8000_0008, 0, 1, 32'hBBBB_BBBB, 64'h8000_0004);
    vecs[6]  = mkVec(0, 0, 64'h0, 1, 0, 64'h0, 1, 34'h0_8000_0008, 0, 0, 32'h0, 64'h0);
    vecs[7]  = mkVec(0, 0, 64'h0, 1, 1, 64'h8000_0104, 1, 34'h0_8000_0008, 0, 0, 32'h0, 64'h0);
    vecs[8]  = mkVec(1, 0, 64'h0, 1, 0, 64'h0, 1, 34'h0_8000_0008, 0, 0, 32'h0, 64'h0);
    vecs[9]  = mkVec(0, 1, 64'hDEAD_BEEF_DEAD_BEEF, 1, 0, 64'h0, 0, 34'h0, 1, 0, 32'h0, 64'h0);
    vecs[10] = mkVec(1, 0, 64'h0, 1, 0, 64'h0, 1, 34'h0_8000_0100, 0, 0, 32'h0, 64'h0);
    vecs[11] = mkVec(0, 1, 64'h2222_2222_1111_1111, 1, 0, 64'h0, 0, 34'h0, 1, 0, 32'h0, 64'h0);
    vecs[12] = mkVec(0, 0, 64'h0, 1, 0, 64'h0, 1, 34'h0_8000_0108, 0, 1, 32'h2222_2222, 64'h8000_0104);
    vecs[13] = mkVec(0, 0, 64'h0, 1, 0, 64'h0, 1, 34'h0_8000_0108, 0, 0, 32'h0, 64'h0);

    $display("[TB] start");
    doReset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].req_ready, vecs[i].res_valid, vecs[i].rdata,
                    vecs[i].inst_ready, vecs[i].redir_valid, vecs[i].redir_pc);
      checkOutput($sformatf("v%0d reqValid", i), 64'(o_req_valid), 64'(vecs[i].exp_req_valid));
      checkOutput($sformatf("v%0d resReady", i), 64'(o_res_ready), 64'(vecs[i].exp_res_ready));
      checkOutput($sformatf("v%0d instValid", i), 64'(o_inst_valid), 64'(vecs[i].exp_inst_valid));
      if (vecs[i].exp_req_valid)
        checkOutput($sformatf("v%0d raddr", i), 64'(o_req_raddr), 64'(vecs[i].exp_raddr));
      if (vecs[i].exp_inst_valid) begin
        checkOutput($sformatf("v%0d inst", i), 64'(o_inst), 64'(vecs[i].exp_inst));
        checkOutput($sformatf("v%0d instPc", i), o_inst_pc, vecs[i].exp_inst_pc);
      end
    end

    // Decode stalled: buffer fills to 4 and requests stop, then drains in order.
    doReset();
    exp_next_pc = 64'h8000_0000;
    popped = 0;
    runCycles(14, 1'b0);
    checkOutput("fullReqValid", 64'(o_req_valid), 64'd0);
    checkOutput("fullInstValid", 64'(o_inst_valid), 64'd1);
    checkOutput("fullHeadPc", o_inst_pc, 64'h8000_0000);
    runCycles(24, 1'b1);
    checkOutput("drainEnough", 64'(popped >= 8), 64'd1);

    // Redirect during WAIT; the late response must be dropped.
    doReset();
    applyStimulus(1, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("cRaddr0", 64'(o_req_raddr), 64'h0_8000_0000);
    applyStimulus(0, 0, 64'h0, 1, 1, 64'h9000_0000);
    checkOutput("cResReady", 64'(o_res_ready), 64'd1);
    applyStimulus(0, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("cDiscardReq", 64'(o_req_valid), 64'd0);
    applyStimulus(0, 0, 64'h0, 1, 0, 64'h0);
    applyStimulus(0, 1, 64'hDEAD_DEAD_DEAD_DEAD, 1, 0, 64'h0);
    checkOutput("cDiscardReady", 64'(o_res_ready), 64'd1);
    applyStimulus(1, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("cEmpty", 64'(o_inst_valid), 64'd0);
    checkOutput("cRaddr1", 64'(o_req_raddr), 64'h0_9000_0000);
    applyStimulus(0, 1, memData(34'h0_9000_0000), 1, 0, 64'h0);
    applyStimulus(0, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("cInstValid", 64'(o_inst_valid), 64'd1);
    checkOutput("cInstPc", o_inst_pc, 64'h9000_0000);
    checkOutput("cInst", 64'(o_inst), 64'(32'h9000_0000 ^ KEY));

    // Redirect in the same cycle as the response.
    doReset();
    applyStimulus(1, 0, 64'h0, 1, 0, 64'h0);
    applyStimulus(0, 1, 64'hDEAD_DEAD_DEAD_DEAD, 1, 1, 64'hA000_000B);
    applyStimulus(1, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("dEmpty", 64'(o_inst_valid), 64'd0);
    checkOutput("dRaddr", 64'(o_req_raddr), 64'h0_A000_0008);
    applyStimulus(0, 1, memData(34'h0_A000_0008), 1, 0, 64'h0);
    applyStimulus(0, 0, 64'h0, 0, 0, 64'h0);
    checkOutput("dInstPc", o_inst_pc, 64'hA000_0008);

    // Redirect in the same cycle as the request handshake goes through DISCARD.
    doReset();
    applyStimulus(1, 0, 64'h0, 1, 1, 64'hB000_0004);
    checkOutput("eRaddr0", 64'(o_req_raddr), 64'h0_8000_0000);
    applyStimulus(0, 1, 64'hDEAD_DEAD_DEAD_DEAD, 1, 0, 64'h0);
    checkOutput("eDiscardReq", 64'(o_req_valid), 64'd0);
    applyStimulus(1, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("eEmpty", 64'(o_inst_valid), 64'd0);
    checkOutput("eRaddr1", 64'(o_req_raddr), 64'h0_B000_0000);
    applyStimulus(0, 1, memData(34'h0_B000_0000), 1, 0, 64'h0);
    applyStimulus(0, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("eInstPc", o_inst_pc, 64'hB000_0004);
    checkOutput("eInst", 64'(o_inst), 64'(32'hB000_0004 ^ KEY));
    applyStimulus(0, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("eOneEntry", 64'(o_inst_valid), 64'd0);

    // Asynchronous reset in the middle of WAIT.
    doReset();
    applyStimulus(1, 0, 64'h0, 1, 0, 64'h0);
    applyStimulus(0, 0, 64'h0, 1, 0, 64'h0);
    checkOutput("fWaitReady", 64'(o_res_ready), 64'd1);
    #2;
    i_rst_n = 1'b0;
    i_res_valid = 1'b1;
    i_res_rdata = memData(34'h0_8000_0000);
    #1;
    checkOutput("fRstReq", 64'(o_req_valid), 64'd0);
    checkOutput("fRstRes", 64'(o_res_ready), 64'd0);
    checkOutput("fRstInst", 64'(o_inst_valid), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_req_ready = 1'b0;
    #1;
    checkOutput("fRelRes", 64'(o_res_ready), 64'd0);
    checkOutput("fRelReq", 64'(o_req_valid), 64'd1);
    checkOutput("fRelRaddr", 64'(o_req_raddr), 64'h0_8000_0000);
    applyStimulus(0, 1, memData(34'h0_8000_0000), 1, 0, 64'h0);
    checkOutput("fLateRes", 64'(o_res_ready), 64'd0);
    checkOutput("fLateInst", 64'(o_inst_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
